// File: rtl/hazard_pkg.sv
// Shared widths, forwarding select codes, the per-stage hazard record and
// the small compare helpers used by the hazard controller.
package hazard_pkg;

  localparam int AW = 5;
  localparam int TW = 2;

  localparam logic [AW-1:0] EPC_ADDR = AW'(14);

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_W   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_E   = 2'd3;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [TW-1:0] tnew;
    logic [AW-1:0] c0_wa;
  } stage_rec_t;

  // How a stage register treats Tnew as the record moves into it.
  typedef enum logic [1:0] {
    TNEW_HOLD = 2'd0,
    TNEW_DEC  = 2'd1,
    TNEW_ZERO = 2'd2
  } tnew_mode_e;

  function automatic logic [TW-1:0] tnew_sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // A consumer must wait while its producer needs more cycles than it can spare.
  function automatic logic data_hazard(input logic [AW-1:0] r,
                                       input logic [TW-1:0] tuse,
                                       input logic [AW-1:0] x_wa,
                                       input logic [TW-1:0] x_tnew);
    return (r != '0) && (r == x_wa) && (tuse < x_tnew);
  endfunction

  function automatic logic [1:0] fwd_sel_id(input logic [AW-1:0] r,
                                            input logic [AW-1:0] e_wa,
                                            input logic [TW-1:0] e_tnew,
                                            input logic [AW-1:0] m_wa,
                                            input logic [TW-1:0] m_tnew,
                                            input logic [AW-1:0] w_wa);
    if (r == '0)                          return FWD_GRF;
    if ((e_wa == r) && (e_tnew == '0))    return FWD_E;
    if ((m_wa == r) && (m_tnew == '0))    return FWD_M;
    if (w_wa == r)                        return FWD_W;
    return FWD_GRF;
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [AW-1:0] r,
                                           input logic [AW-1:0] m_wa,
                                           input logic [TW-1:0] m_tnew,
                                           input logic [AW-1:0] w_wa);
    if (r == '0)                          return FWD_GRF;
    if ((m_wa == r) && (m_tnew == '0))    return FWD_M;
    if (w_wa == r)                        return FWD_W;
    return FWD_GRF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_stage_reg.sv
// One pipeline hazard record register: clear, bubble or load, with Tnew
// held, aged by one (saturating) or zeroed on the way in.
module hz_stage_reg
  import hazard_pkg::*;
#(
  parameter tnew_mode_e MODE = TNEW_HOLD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_bubble,
  input  logic       i_load,
  input  stage_rec_t i_rec,
  output stage_rec_t o_rec
);

  stage_rec_t r_rec;
  stage_rec_t w_next;

  always_comb begin
    w_next = i_rec;
    case (MODE)
      TNEW_DEC:  w_next.tnew = tnew_sat_dec(i_rec.tnew);
      TNEW_ZERO: w_next.tnew = '0;
      default:   w_next.tnew = i_rec.tnew;
    endcase
  end

  // Clear wins over bubble, bubble wins over load.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_rec <= '0;
    end else if (i_bubble) begin
      r_rec <= '0;
    end else if (i_load) begin
      r_rec <= w_next;
    end
  end

  assign o_rec = r_rec;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W producer records and derives the
// ID stall, E bubble and all forwarding selects of the 5-stage pipeline.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] RA1_ID,
  input  logic [AW-1:0] RA2_ID,
  input  logic [AW-1:0] WA_ID,
  input  logic [TW-1:0] Tuse_RA1,
  input  logic [TW-1:0] Tuse_RA2,
  input  logic [TW-1:0] Tnew_ID,
  input  logic [AW-1:0] c0_WA_ID,
  input  logic          eret_ID,
  input  logic          md_ID,
  input  logic          md_start_E,
  input  logic          md_busy,
  input  logic          flush,
  output logic          stall,
  output logic          bubble_E,
  output logic [1:0]    fwd_RA1_ID,
  output logic [1:0]    fwd_RA2_ID,
  output logic [1:0]    fwd_RA1_E,
  output logic [1:0]    fwd_RA2_E,
  output logic          fwd_RA2_M
);

  stage_rec_t    w_rec_id;
  stage_rec_t    w_rec_e;
  stage_rec_t    w_rec_m;
  stage_rec_t    w_rec_w;
  logic [AW-1:0] r_ra1_e;
  logic [AW-1:0] r_ra2_e;
  logic [AW-1:0] r_ra2_m;
  logic          w_stall_data;
  logic          w_stall_md;
  logic          w_stall_cp0;
  logic          w_stall;
  logic          w_unused_w;

  assign w_rec_id = '{wa: WA_ID, tnew: Tnew_ID, c0_wa: c0_WA_ID};

  hz_stage_reg #(.MODE(TNEW_HOLD)) u_stage_e (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (flush),
    .i_bubble (w_stall),
    .i_load   (1'b1),
    .i_rec    (w_rec_id),
    .o_rec    (w_rec_e)
  );

  hz_stage_reg #(.MODE(TNEW_DEC)) u_stage_m (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (flush),
    .i_bubble (1'b0),
    .i_load   (1'b1),
    .i_rec    (w_rec_e),
    .o_rec    (w_rec_m)
  );

  hz_stage_reg #(.MODE(TNEW_ZERO)) u_stage_w (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (flush),
    .i_bubble (1'b0),
    .i_load   (1'b1),
    .i_rec    (w_rec_m),
    .o_rec    (w_rec_w)
  );

  // W keeps the full record for uniformity; only its WA is ever compared.
  assign w_unused_w = ^{w_rec_w.tnew, w_rec_w.c0_wa};

  // Source addresses ride alongside the records for E and M forwarding.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_ra1_e <= '0;
      r_ra2_e <= '0;
      r_ra2_m <= '0;
    end else begin
      r_ra2_m <= r_ra2_e;
      if (w_stall) begin
        r_ra1_e <= '0;
        r_ra2_e <= '0;
      end else begin
        r_ra1_e <= RA1_ID;
        r_ra2_e <= RA2_ID;
      end
    end
  end

  always_comb begin
    w_stall_data = data_hazard(RA1_ID, Tuse_RA1, w_rec_e.wa, w_rec_e.tnew)
                 | data_hazard(RA2_ID, Tuse_RA2, w_rec_e.wa, w_rec_e.tnew)
                 | data_hazard(RA1_ID, Tuse_RA1, w_rec_m.wa, w_rec_m.tnew)
                 | data_hazard(RA2_ID, Tuse_RA2, w_rec_m.wa, w_rec_m.tnew);
    w_stall_md   = md_ID & (md_busy | md_start_E);
    w_stall_cp0  = eret_ID & ((w_rec_e.c0_wa == EPC_ADDR) | (w_rec_m.c0_wa == EPC_ADDR));
    w_stall      = w_stall_data | w_stall_md | w_stall_cp0;
  end

  assign stall    = w_stall;
  assign bubble_E = w_stall;

  assign fwd_RA1_ID = fwd_sel_id(RA1_ID, w_rec_e.wa, w_rec_e.tnew,
                                 w_rec_m.wa, w_rec_m.tnew, w_rec_w.wa);
  assign fwd_RA2_ID = fwd_sel_id(RA2_ID, w_rec_e.wa, w_rec_e.tnew,
                                 w_rec_m.wa, w_rec_m.tnew, w_rec_w.wa);
  assign fwd_RA1_E  = fwd_sel_e(r_ra1_e, w_rec_m.wa, w_rec_m.tnew, w_rec_w.wa);
  assign fwd_RA2_E  = fwd_sel_e(r_ra2_e, w_rec_m.wa, w_rec_m.tnew, w_rec_w.wa);
  assign fwd_RA2_M  = (r_ra2_m != '0) && (r_ra2_m == w_rec_w.wa);

endmodule
